// File: rtl/regfile_scoreboard.sv
// Integer register file with per-entry busy scoreboard and post-reset clearing sweep.
// Optional same-cycle write-to-read bypass enabled by defining RF_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready,
    input  logic [AW-1:0]   rd_addr1,
    input  logic [AW-1:0]   rd_addr2,
    output logic [XLEN-1:0] rd_data1,
    output logic [XLEN-1:0] rd_data2,
    output logic            rd_busy1,
    output logic            rd_busy2,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            claim_en,
    input  logic [AW-1:0]   claim_addr,
    output logic [AW:0]     pending_cnt
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = AW + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [CW-1:0]     cnt_nxt;
    logic              wr_ok, cl_ok, inc, dec;

    // State register plus the registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            ready       <= 1'b0;
            idx         <= '0;
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            state       <= state_nxt;
            ready       <= (state_nxt == RUN);
            busy        <= busy_nxt;
            pending_cnt <= cnt_nxt;
            if (state == INIT) begin
                idx <= idx + AW'(1);
            end
        end
    end

    // Next state, accepted write/claim, scoreboard update
    always_comb begin
        state_nxt = state;
        wr_ok     = 1'b0;
        cl_ok     = 1'b0;
        case (state)
            INIT: begin
                if (idx == LAST_IDX) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                wr_ok = we && (wr_addr != '0);
                cl_ok = claim_en && (claim_addr != '0);
            end
            default: state_nxt = INIT;
        endcase

        // A claim on the same edge as a write wins: a new producer has issued
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (cl_ok) begin
            busy_nxt[claim_addr] = 1'b1;
        end
        inc     = cl_ok && !busy[claim_addr];
        dec     = wr_ok && busy[wr_addr] && !(cl_ok && (claim_addr == wr_addr));
        cnt_nxt = pending_cnt + CW'(inc) - CW'(dec);
    end

    // Storage has no reset; the sweep zeroes it before ready rises
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[idx] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        if (ready && (rd_addr1 != '0)) begin
            rd_data1 = mem[rd_addr1];
            rd_busy1 = busy[rd_addr1];
`ifdef RF_BYPASS_EN
            if (we && (wr_addr == rd_addr1)) begin
                rd_data1 = wr_data;
                rd_busy1 = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (ready && (rd_addr2 != '0)) begin
            rd_data2 = mem[rd_addr2];
            rd_busy2 = busy[rd_addr2];
`ifdef RF_BYPASS_EN
            if (we && (wr_addr == rd_addr2)) begin
                rd_data2 = wr_data;
                rd_busy2 = 1'b0;
            end
`endif
        end
    end

endmodule
